regfile_write_queue: RTL
========================

REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of registers; power of two, 2..64.
REQ-002 SHALL have parameter DATA_W, default 16, write-data width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-004 SHALL have parameter ZERO_REG_EN, default 0; 1 = register 0 hard-wired, writes to it discarded.
REQ-005 SHALL derive localparam ADDR_W = log2(NUM_REGS) and CNT_W = log2(DEPTH)+1.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush  in  1  discard all queued writes.
REQ-009 wr_valid  in  1  write request present.
REQ-010 wr_ready  out  1  queue can accept.
REQ-011 wr_reg_id  in  ADDR_W  destination register.
REQ-012 wr_data  in  DATA_W  write value.
REQ-013 drain_en  in  1  register file may take one write this cycle.
REQ-014 wordline  out  NUM_REGS  one-hot write enable to register file, all-zero when idle.
REQ-015 wl_data  out  DATA_W  data accompanying wordline.
REQ-016 rd_reg_id  in  ADDR_W  forwarding lookup address.
REQ-017 rd_hit  out  1  a queued write targets rd_reg_id.
REQ-018 rd_data  out  DATA_W  value of youngest matching queued write; 0 when no hit.
REQ-019 count  out  CNT_W  occupied entries, 0..DEPTH.

Function
REQ-020 SHALL hold writes in a circular FIFO of DEPTH entries {reg_id, data} with head/tail pointers wrapping modulo DEPTH.
REQ-021 SHALL drive wr_ready = (count != DEPTH) && !flush, from registered state only.
REQ-022 Push SHALL occur at the edge where wr_valid && wr_ready; entry written at tail, tail advances.
REQ-023 With ZERO_REG_EN=1 and wr_reg_id==0, handshake SHALL complete but nothing is enqueued.
REQ-024 Pop SHALL occur when drain_en && count!=0; same cycle wordline = one-hot(head reg_id), wl_data = head data (combinational from head, zero latency); head advances at edge.
REQ-025 When no pop, wordline SHALL be all-zero and wl_data SHALL be 0.
REQ-026 wordline SHALL never have more than one bit set.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; full queue with drain_en does not accept in same cycle (wr_ready uses registered count).
REQ-028 Push to empty queue SHALL not drain in the same cycle; earliest drain is the following cycle (one-cycle minimum latency).
REQ-029 Writes SHALL leave in acceptance order; multiple entries for same register permitted.
REQ-030 rd_hit/rd_data SHALL be combinational over valid entries, youngest match wins, entry popping this cycle still counted.
REQ-031 flush SHALL take priority: at the edge, count, head, tail -> 0; concurrent push dropped; pop in flush cycle still drives wordline (write in flight completes).
REQ-032 count SHALL equal pushes minus pops since last reset/flush, never exceeding DEPTH.

Reset
REQ-033 On rst high, count, head, tail SHALL clear to 0 immediately, without clock; wordline=0, wl_data=0, rd_hit=0, wr_ready=0 while rst asserted.
REQ-034 Entry storage SHALL not require reset; validity is derived solely from pointers/count.
REQ-035 Reset mid-operation SHALL discard all queued writes; first accepted write after release is entry 0.

Structure
REQ-036 A shared package SHALL hold defaults NUM_REGS=16, DATA_W=16 and the entry struct type {reg_id, data}.
REQ-037 One sub-module, onehot_decoder (ADDR_W -> NUM_REGS with enable), SHALL generate wordline; no other sub-modules.

Verification
REQ-038 Reset then push (reg 3, 0xABCD), drain_en=1 next cycle -> wordline=16'h0008, wl_data=0xABCD for exactly one cycle, count 1->0.
REQ-039 Fill 4 entries with drain_en=0 -> count=4, wr_ready=0; fifth request stalls; enable drain -> wordlines in push order.
REQ-040 Push reg 5 = 0x1111 then reg 5 = 0x2222, rd_reg_id=5 -> rd_hit=1, rd_data=0x2222; rd_reg_id=6 -> rd_hit=0, rd_data=0.
REQ-041 ZERO_REG_EN=1, push reg 0 -> wr_ready handshake completes, count stays 0, wordline never 16'h0001.
REQ-042 Queue holding 3 entries, flush with concurrent push -> next cycle count=0, pushed write never appears on wordline.
REQ-043 Assert rst asynchronously between edges with count=2 -> count=0, wordline=0 before next clock edge; random push/drain run for 1000 cycles checks one-hot and ordering against a reference queue model.

Source files
------------

// File: rtl/regfile_write_queue_pkg.sv
// regfile_write_queue_pkg: shared defaults and the queue entry layout
package regfile_write_queue_pkg;
  localparam int NUM_REGS_DEF = 16;
  localparam int DATA_W_DEF = 16;
  typedef struct packed {
    logic [$clog2(NUM_REGS_DEF)-1:0] regId;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/regfile_write_queue_onehot_decoder.sv
// onehot_decoder: enabled binary-to-one-hot decode, all-zero when disabled
module onehot_decoder #(
  parameter int ADDR_W = 4,
  parameter int NUM_OUT = 16
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NUM_OUT-1:0] onehot
);
  always_comb onehot = en ? (NUM_OUT'(1) << addr) : '0;
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: circular write FIFO draining one write per cycle into a register file,
// with youngest-match forwarding over the queued entries.
module regfile_write_queue import regfile_write_queue_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4,
  parameter bit ZERO_REG_EN = 1'b0,
  localparam int ADDR_W = $clog2(NUM_REGS),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_reg_id,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                drain_en,
  output logic [NUM_REGS-1:0] wordline,
  output logic [DATA_W-1:0]   wl_data,
  input  logic [ADDR_W-1:0]   rd_reg_id,
  output logic                rd_hit,
  output logic [DATA_W-1:0]   rd_data,
  output logic [CNT_W-1:0]    count
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef struct packed {
    logic [ADDR_W-1:0] regId;
    logic [DATA_W-1:0] data;
  } slot_t;
  slot_t mem [DEPTH];
  logic [PTR_W-1:0] head, tail, idx;
  logic push, pop, accept;
  assign wr_ready = !rst && count != CNT_W'(DEPTH) && !flush;
  assign accept = wr_valid && wr_ready;
  // A handshake to a hard-wired register 0 completes but stores nothing
  assign push = accept && !(ZERO_REG_EN && wr_reg_id == '0);
  assign pop = drain_en && count != '0;
  assign wl_data = pop ? mem[head].data : '0;
  onehot_decoder #(.ADDR_W(ADDR_W), .NUM_OUT(NUM_REGS)) uDec (
    .en(pop),
    .addr(mem[head].regId),
    .onehot(wordline)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[tail] <= '{regId: wr_reg_id, data: wr_data};
  // Scan oldest to youngest so the last valid match is the one reported
  always_comb begin
    rd_hit = 1'b0;
    rd_data = '0;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count && mem[idx].regId == rd_reg_id) begin
        rd_hit = 1'b1;
        rd_data = mem[idx].data;
      end
    end
  end
endmodule
